ntt_writeback_addr_gen: RTL
===========================

# ntt_writeback_addr_gen

Write-side address generator for the radix-2, 4-BFU NTT datapath on the 1024-entry coefficient memory. It accepts the same (k, i, p) loop triplet that drives the read-side address generation, delays it through a shift pipeline matched to the butterfly latency, and emits the eight in-place write-back addresses with a write enable. It also counts write beats per stage, pulses a completion flag after each full stage, and flags illegal stage indices and sequencing errors.

## Interface
Parameters:
- LAT, 4, cycles from in_valid to wr_en; legal range 1..16; equals BFU pipeline depth plus memory read latency.
- BEATS_PER_STAGE, 128, write beats per NTT stage (1024 coefficients / 8 per beat).

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  triplet valid this cycle.
- k  input  7  butterfly group index.
- i  input  7  index within group.
- p  input  4  stage index, legal 0..9.
- wr_en  output  1  write beat valid.
- wr_address_0 .. wr_address_7  output  10 each  write addresses, lane n → wr_address_n.
- stage_done  output  1  one-cycle pulse on the final beat of a stage.
- done_stage  output  4  p of the completed stage; valid while stage_done=1.
- seq_err  output  1  sticky error flag.

## Operation
- Address mapping, computed on in_valid, all arithmetic 10-bit, wrap mod 1024:
  - p=0: lane n = 8k + n.
  - p=1: lanes 0..7 = 8k + {0,2,1,3,4,6,5,7}.
  - p=2..9: base = (k << (p+1)) + (i << 2); even lanes 0,2,4,6 = base+0, +1, +2, +3; each odd lane 2m+1 = lane 2m with bit p set.
- Out-of-range k/i for a given p produce no error; the result simply wraps.
- Pipeline: address computation registers in stage 1; stages 2..LAT are plain shift registers carrying {valid, p, 8 addresses}. Full throughput, one beat per cycle, no back-pressure.
- p>9 on in_valid: the beat is dropped (valid not entered into the pipeline) and seq_err is set.
- Beat counter (7-bit) and last_p register, both updated on each output beat (wr_en=1):
  - If the counter is nonzero and the beat's p ≠ last_p: set seq_err and restart the count at 1 for the new p.
  - Otherwise increment the counter.
  - On reaching BEATS_PER_STAGE: pulse stage_done in the same cycle as that wr_en, drive done_stage = p, and wrap the counter to 0.
- seq_err clears only on rst.

## Timing
- in_valid at edge t → wr_en and addresses valid after edge t+LAT; exactly LAT cycles of latency.
- Addresses are don't-care when wr_en=0; they hold their last value.
- stage_done and done_stage are registered together with the final beat (same cycle as wr_en).
- seq_err for p>9 asserts after edge t+1. seq_err for a p change asserts in the cycle after the offending wr_en.
- Reset values: wr_en=0, all wr_address_n=0, stage_done=0, done_stage=0, seq_err=0, beat counter=0, last_p=0, and all pipeline valid bits=0.
- Reset asserted mid-flight discards every in-flight beat. No wr_en appears for triplets accepted before reset. The first beat accepted after release appears LAT cycles later.
- Gaps in in_valid are carried through unchanged. The beat counter does not reset across gaps.

## Test plan
- p=0, k=5, single beat → at t+4: wr_en=1, addresses 40,41,…,47; stage_done=0.
- p=1, k=3 → addresses 24,26,25,27,28,30,29,31.
- p=3, k=2, i=1 → addresses 36,44,37,45,38,46,39,47. Then p=9, k=0, i=127 → 508,1020,509,1021,510,1022,511,1023.
- 128 back-to-back p=2 beats (k and i swept) → 128 consecutive wr_en. stage_done pulses only on the 128th beat with done_stage=2, and the counter returns to 0. Then 128 p=3 beats → a second pulse with done_stage=3. seq_err stays 0 throughout.
- 10 p=4 beats followed by one p=5 beat → seq_err=1 and stays set. Another 127 p=5 beats then complete the stage, giving stage_done with done_stage=5.
- Three beats in flight, rst pulsed at t+2 → no wr_en for those beats and all outputs 0. Separately, p=10 on in_valid → no wr_en and seq_err=1.

Source files
------------

// File: rtl/ntt_writeback_addr_gen_if.sv
// Purpose: bus bundle between the NTT loop sequencer and the write-back
// address generator.
//   in_valid, k, i, p       : loop triplet from the sequencer
//   wr_en, wr_address_0..7  : write beat towards the coefficient memory
//   stage_done, done_stage  : end-of-stage pulse and the stage it closed
//   seq_err                 : sticky sequencing / illegal-stage flag
// slave is the generator side, master is the sequencer/memory side.
interface ntt_writeback_addr_gen_if;
  logic       in_valid;
  logic [6:0] k;
  logic [6:0] i;
  logic [3:0] p;
  logic       wr_en;
  logic [9:0] wr_address_0;
  logic [9:0] wr_address_1;
  logic [9:0] wr_address_2;
  logic [9:0] wr_address_3;
  logic [9:0] wr_address_4;
  logic [9:0] wr_address_5;
  logic [9:0] wr_address_6;
  logic [9:0] wr_address_7;
  logic       stage_done;
  logic [3:0] done_stage;
  logic       seq_err;

  modport slave (
    input  in_valid, k, i, p,
    output wr_en, wr_address_0, wr_address_1, wr_address_2, wr_address_3,
           wr_address_4, wr_address_5, wr_address_6, wr_address_7,
           stage_done, done_stage, seq_err
  );

  modport master (
    output in_valid, k, i, p,
    input  wr_en, wr_address_0, wr_address_1, wr_address_2, wr_address_3,
           wr_address_4, wr_address_5, wr_address_6, wr_address_7,
           stage_done, done_stage, seq_err
  );
endinterface

// File: rtl/ntt_writeback_addr_gen.sv
// Purpose: write-side address generator for the radix-2, 4-BFU NTT on the
// 1024-entry coefficient memory. Maps each (k, i, p) triplet to eight in-place
// write addresses, delays them by LAT cycles to line up with the butterflies,
// counts beats per stage and flags stage completion and sequencing errors.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : slave side of ntt_writeback_addr_gen_if (triplet in, write beat,
//          stage_done/done_stage and seq_err out)
module ntt_writeback_addr_gen #(
  parameter int unsigned LAT             = 4,
  parameter int unsigned BEATS_PER_STAGE = 128
) (
  input logic                     clk,
  input logic                     rst,
  ntt_writeback_addr_gen_if.slave bus
);

  localparam int unsigned AW    = 10;
  localparam int unsigned PW    = 4;
  localparam int unsigned LANES = 8;
  localparam int unsigned CNT_W = (BEATS_PER_STAGE > 1) ? $clog2(BEATS_PER_STAGE) : 1;
  localparam logic [CNT_W:0] BEATS_CMP = (CNT_W + 1)'(BEATS_PER_STAGE);
  localparam logic [PW-1:0]  P_MAX     = PW'(9);
  // Lane offsets for stage 1 (lane7 .. lane0)
  localparam logic [LANES-1:0][2:0] P1_PERM =
    {3'd7, 3'd5, 3'd6, 3'd4, 3'd3, 3'd1, 3'd2, 3'd0};

  typedef struct packed {
    logic                     valid;
    logic [PW-1:0]            p;
    logic [LANES-1:0][AW-1:0] addr;
  } beat_t;

  beat_t            comp;
  beat_t            pipe [LAT];
  logic             p_bad;
  logic             feed_valid;
  logic [PW-1:0]    feed_p;
  logic [AW-1:0]    k8;
  logic [AW-1:0]    base;
  logic [4:0]       sh;

  logic [CNT_W-1:0] cnt;
  logic [PW-1:0]    last_p;
  logic             mismatch;
  logic [CNT_W:0]   cnt_inc;
  logic             last_beat;
  logic             chg_err;
  logic             stage_done_q;
  logic             seq_err_q;

  // Address mapping for the incoming triplet (stage 1 input)
  always_comb begin
    comp       = '0;
    p_bad      = bus.in_valid && (bus.p > P_MAX);
    comp.valid = bus.in_valid && !p_bad;
    comp.p     = bus.p;
    k8         = AW'({bus.k, 3'b000});
    sh         = 5'(bus.p) + 5'd1;
    base       = (AW'(bus.k) << sh) + (AW'(bus.i) << 2);
    case (bus.p)
      PW'(0): for (int n = 0; n < LANES; n++) comp.addr[n] = k8 + AW'(n);
      PW'(1): for (int n = 0; n < LANES; n++) comp.addr[n] = k8 + AW'(P1_PERM[n]);
      default: begin
        // even lane 2m = base+m, its odd partner differs only in bit p
        for (int m = 0; m < LANES / 2; m++) begin
          comp.addr[2*m]   = base + AW'(m);
          comp.addr[2*m+1] = comp.addr[2*m] | (AW'(1) << bus.p);
        end
      end
    endcase
  end

  // Latency pipeline; payload only loads with a valid beat so outputs hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < LAT; j++) pipe[j] <= '0;
    end else begin
      pipe[0].valid <= comp.valid;
      if (comp.valid) begin
        pipe[0].p    <= comp.p;
        pipe[0].addr <= comp.addr;
      end
      for (int j = 1; j < LAT; j++) begin
        pipe[j].valid <= pipe[j-1].valid;
        if (pipe[j-1].valid) begin
          pipe[j].p    <= pipe[j-1].p;
          pipe[j].addr <= pipe[j-1].addr;
        end
      end
    end
  end

  // Beat about to enter the output register
  if (LAT == 1) begin : g_feed_direct
    assign feed_valid = comp.valid;
    assign feed_p     = comp.p;
  end else begin : g_feed_pipe
    assign feed_valid = pipe[LAT-2].valid;
    assign feed_p     = pipe[LAT-2].p;
  end

  // Stage beat accounting for the beat being registered onto the outputs
  always_comb begin
    mismatch  = feed_valid && (cnt != '0) && (feed_p != last_p);
    cnt_inc   = mismatch ? (CNT_W + 1)'(1) : ({1'b0, cnt} + (CNT_W + 1)'(1));
    last_beat = feed_valid && (cnt_inc == BEATS_CMP);
  end

  // Counter, completion pulse and sticky error; seq_err lags its cause by one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt          <= '0;
      last_p       <= '0;
      stage_done_q <= 1'b0;
      chg_err      <= 1'b0;
      seq_err_q    <= 1'b0;
    end else begin
      stage_done_q <= last_beat;
      chg_err      <= mismatch;
      seq_err_q    <= seq_err_q | chg_err | p_bad;
      if (feed_valid) begin
        last_p <= feed_p;
        cnt    <= last_beat ? '0 : CNT_W'(cnt_inc);
      end
    end
  end

  assign bus.wr_en        = pipe[LAT-1].valid;
  assign bus.wr_address_0 = pipe[LAT-1].addr[0];
  assign bus.wr_address_1 = pipe[LAT-1].addr[1];
  assign bus.wr_address_2 = pipe[LAT-1].addr[2];
  assign bus.wr_address_3 = pipe[LAT-1].addr[3];
  assign bus.wr_address_4 = pipe[LAT-1].addr[4];
  assign bus.wr_address_5 = pipe[LAT-1].addr[5];
  assign bus.wr_address_6 = pipe[LAT-1].addr[6];
  assign bus.wr_address_7 = pipe[LAT-1].addr[7];
  assign bus.stage_done   = stage_done_q;
  // p of the beat on the outputs; meaningful while stage_done is high
  assign bus.done_stage   = pipe[LAT-1].p;
  assign bus.seq_err      = seq_err_q;

endmodule
